pipe_mem_arbiter: RTL and testbench

//  Shares the single Avalon-style memory port between instruction fetch and the MEM-stage data access.

---
 rtl/pipe_mem_arbiter_pkg.sv | 21 ++
 rtl/pipe_mem_arbiter_if.sv | 43 ++++
 rtl/pipe_mem_arbiter_timer.sv | 25 ++
 rtl/pipe_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_pipe_mem_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package pipe_mem_arbiter_pkg;

    localparam int unsigned AVM_BE_W = 4;
    localparam logic [AVM_BE_W-1:0] BE_ALL = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D_BUS,
        ST_D_RD,
        ST_F_BUS,
        ST_F_RD,
        ST_DONE
    } arb_state_t;

    // Avalon transfer accepted this cycle
    function automatic logic avm_accept(input logic rd, input logic wr, input logic waitreq);
        return (rd | wr) & ~waitreq;
    endfunction

endpackage

// File: rtl/pipe_mem_arbiter_if.sv
// Pipeline-side request/response and Avalon memory signals of the arbiter.
interface pipe_mem_arbiter_if
    import pipe_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic                d_read;
    logic                d_write;
    logic [ADDR_W-1:0]   d_addr;
    logic [AVM_BE_W-1:0] d_byteenable;
    logic [DATA_W-1:0]   d_writedata;
    logic                fetch_sel;
    logic                stall;
    logic [DATA_W-1:0]   if_rdata;
    logic                if_valid;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_valid;
    logic                bus_err;
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_read;
    logic                avm_write;
    logic [AVM_BE_W-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_writedata;
    logic                avm_waitrequest;
    logic [DATA_W-1:0]   avm_readdata;

    modport master (
        input  if_req, if_addr, d_read, d_write, d_addr, d_byteenable, d_writedata,
        input  avm_waitrequest, avm_readdata,
        output fetch_sel, stall, if_rdata, if_valid, d_rdata, d_valid, bus_err,
        output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
    );

    modport slave (
        output if_req, if_addr, d_read, d_write, d_addr, d_byteenable, d_writedata,
        output avm_waitrequest, avm_readdata,
        input  fetch_sel, stall, if_rdata, if_valid, d_rdata, d_valid, bus_err,
        input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
    );
endinterface

// File: rtl/pipe_mem_arbiter_timer.sv
// Waitrequest counter; flags the cycle on which an access has waited MAX_WAIT cycles.
module pipe_mem_arbiter_timer #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_busy,
    input  logic i_waitreq,
    output logic o_timeout_c
);
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_timeout_c = i_busy & i_waitreq & (r_cnt == CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (i_busy & i_waitreq & ~o_timeout_c)
            r_cnt <= r_cnt + CNT_W'(1);
        else
            r_cnt <= '0;
    end
endmodule

// File: rtl/pipe_mem_arbiter.sv
// Serialises one data access then one instruction fetch per pipeline advance onto a single Avalon port.
module pipe_mem_arbiter
    import pipe_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    pipe_mem_arbiter_if.master bus
);
    arb_state_t          r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic                r_read, w_read_nxt;
    logic                r_write, w_write_nxt;
    logic [AVM_BE_W-1:0] r_be, w_be_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0]   r_if_rdata, w_if_rdata_nxt;
    logic [DATA_W-1:0]   r_d_rdata, w_d_rdata_nxt;
    logic                r_if_valid, w_if_valid_nxt;
    logic                r_d_valid, w_d_valid_nxt;
    logic                r_bus_err, w_bus_err_nxt;
    logic                r_to, w_to_nxt;
    logic                r_d_served, w_d_served_nxt;
    logic                r_load, w_load_nxt;
    logic                r_fetch, w_fetch_nxt;
    logic                w_timeout, w_bus_done, w_d_req, w_start_fetch;

    pipe_mem_arbiter_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_busy      (r_read | r_write),
        .i_waitreq   (bus.avm_waitrequest),
        .o_timeout_c (w_timeout)
    );

    assign w_bus_done = avm_accept(r_read, r_write, bus.avm_waitrequest) | w_timeout;
    assign w_d_req    = bus.d_read | bus.d_write;

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_read_nxt     = r_read;
        w_write_nxt    = r_write;
        w_be_nxt       = r_be;
        w_wdata_nxt    = r_wdata;
        w_if_rdata_nxt = r_if_rdata;
        w_d_rdata_nxt  = r_d_rdata;
        w_if_valid_nxt = 1'b0;
        w_d_valid_nxt  = 1'b0;
        w_bus_err_nxt  = r_bus_err | w_timeout;
        w_to_nxt       = r_to;
        w_d_served_nxt = r_d_served;
        w_load_nxt     = r_load;
        w_fetch_nxt    = r_fetch;
        w_start_fetch  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_d_served_nxt = 1'b0;
                w_load_nxt     = 1'b0;
                w_fetch_nxt    = 1'b0;
                w_to_nxt       = 1'b0;
                if (w_d_req) begin
                    // simultaneous read and write resolves to a write
                    w_state_nxt    = ST_D_BUS;
                    w_addr_nxt     = bus.d_addr;
                    w_read_nxt     = bus.d_read & ~bus.d_write;
                    w_write_nxt    = bus.d_write;
                    w_be_nxt       = bus.d_byteenable;
                    w_wdata_nxt    = bus.d_writedata;
                    w_d_served_nxt = 1'b1;
                    w_load_nxt     = bus.d_read & ~bus.d_write;
                end else if (bus.if_req) begin
                    w_start_fetch = 1'b1;
                end
            end
            ST_D_BUS: begin
                if (w_bus_done) begin
                    w_read_nxt  = 1'b0;
                    w_write_nxt = 1'b0;
                    w_to_nxt    = w_timeout;
                    if (r_load)
                        w_state_nxt = ST_D_RD;
                    else if (bus.if_req)
                        w_start_fetch = 1'b1;
                    else
                        w_state_nxt = ST_DONE;
                end
            end
            ST_D_RD: begin
                w_d_rdata_nxt = r_to ? '0 : bus.avm_readdata;
                w_to_nxt      = 1'b0;
                if (bus.if_req)
                    w_start_fetch = 1'b1;
                else
                    w_state_nxt = ST_DONE;
            end
            ST_F_BUS: begin
                if (w_bus_done) begin
                    w_read_nxt  = 1'b0;
                    w_to_nxt    = w_timeout;
                    w_state_nxt = ST_F_RD;
                end
            end
            ST_F_RD: begin
                w_if_rdata_nxt = r_to ? '0 : bus.avm_readdata;
                w_state_nxt    = ST_DONE;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        if (w_start_fetch) begin
            w_state_nxt = ST_F_BUS;
            w_addr_nxt  = bus.if_addr;
            w_read_nxt  = 1'b1;
            w_write_nxt = 1'b0;
            w_be_nxt    = BE_ALL;
            w_fetch_nxt = 1'b1;
            w_to_nxt    = 1'b0;
        end

        // valids pulse only during the single DONE cycle
        if (w_state_nxt == ST_DONE && r_state != ST_DONE) begin
            w_if_valid_nxt = w_fetch_nxt;
            w_d_valid_nxt  = w_load_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_bus_err  <= 1'b0;
            r_to       <= 1'b0;
            r_d_served <= 1'b0;
            r_load     <= 1'b0;
            r_fetch    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_read     <= w_read_nxt;
            r_write    <= w_write_nxt;
            r_be       <= w_be_nxt;
            r_wdata    <= w_wdata_nxt;
            r_if_rdata <= w_if_rdata_nxt;
            r_d_rdata  <= w_d_rdata_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_d_valid  <= w_d_valid_nxt;
            r_bus_err  <= w_bus_err_nxt;
            r_to       <= w_to_nxt;
            r_d_served <= w_d_served_nxt;
            r_load     <= w_load_nxt;
            r_fetch    <= w_fetch_nxt;
        end
    end

    assign bus.stall     = (r_state != ST_DONE) & ((r_state != ST_IDLE) | w_d_req | bus.if_req);
    assign bus.fetch_sel = (r_state == ST_F_BUS) | (r_state == ST_F_RD) |
                           ((r_state == ST_DONE) & ~r_d_served);

    assign bus.avm_address    = r_addr;
    assign bus.avm_read       = r_read;
    assign bus.avm_write      = r_write;
    assign bus.avm_byteenable = r_be;
    assign bus.avm_writedata  = r_wdata;
    assign bus.if_rdata       = r_if_rdata;
    assign bus.d_rdata        = r_d_rdata;
    assign bus.if_valid       = r_if_valid;
    assign bus.d_valid        = r_d_valid;
    assign bus.bus_err        = r_bus_err;
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: fetch, store+fetch, waited load, timeout, reset, idle.
module tb_pipe_mem_arbiter;
    logic clk;
    logic reset_n;
    int   n_assert;
    int   n_fail;

    pipe_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    pipe_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_req();
        bus.if_req       = 1'b0;
        bus.if_addr      = '0;
        bus.d_read       = 1'b0;
        bus.d_write      = 1'b0;
        bus.d_addr       = '0;
        bus.d_byteenable = '0;
        bus.d_writedata  = '0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        clear_req();
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = '0;
        repeat (3) tick();

        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_avm_read", 32'(bus.avm_read), 32'd0);
        check("rst_avm_write", 32'(bus.avm_write), 32'd0);
        check("rst_bus_err", 32'(bus.bus_err), 32'd0);
        check("rst_valids", 32'({bus.if_valid, bus.d_valid}), 32'd0);
        check("rst_d_rdata", bus.d_rdata, 32'd0);
        check("rst_if_rdata", bus.if_rdata, 32'd0);
        reset_n = 1'b1;

        // idle: no requests
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_stall", 32'(bus.stall), 32'd0);
            check("idle_strobes", 32'({bus.avm_read, bus.avm_write}), 32'd0);
        end

        // fetch only
        bus.if_req = 1'b1;
        bus.if_addr = 32'h40;
        bus.avm_readdata = 32'h2408_0005;
        #1;
        check("f_idle_stall", 32'(bus.stall), 32'd1);
        tick();
        check("f_bus_read", 32'(bus.avm_read), 32'd1);
        check("f_bus_addr", bus.avm_address, 32'h40);
        check("f_bus_be", 32'(bus.avm_byteenable), 32'hF);
        check("f_bus_sel", 32'(bus.fetch_sel), 32'd1);
        check("f_bus_stall", 32'(bus.stall), 32'd1);
        tick();
        check("f_rd_read", 32'(bus.avm_read), 32'd0);
        check("f_rd_sel", 32'(bus.fetch_sel), 32'd1);
        check("f_rd_stall", 32'(bus.stall), 32'd1);
        tick();
        check("f_done_stall", 32'(bus.stall), 32'd0);
        check("f_done_ifv", 32'(bus.if_valid), 32'd1);
        check("f_done_dv", 32'(bus.d_valid), 32'd0);
        check("f_done_rdata", bus.if_rdata, 32'h2408_0005);
        check("f_done_sel", 32'(bus.fetch_sel), 32'd1);
        clear_req();
        tick();
        check("f_idle_ifv", 32'(bus.if_valid), 32'd0);

        // store then fetch
        bus.d_write = 1'b1;
        bus.d_addr = 32'h100;
        bus.d_byteenable = 4'b0011;
        bus.d_writedata = 32'hDEAD_BEEF;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h4;
        bus.avm_readdata = 32'h1111_2222;
        tick();
        check("s_bus_write", 32'(bus.avm_write), 32'd1);
        check("s_bus_read", 32'(bus.avm_read), 32'd0);
        check("s_bus_addr", bus.avm_address, 32'h100);
        check("s_bus_be", 32'(bus.avm_byteenable), 32'h3);
        check("s_bus_wdata", bus.avm_writedata, 32'hDEAD_BEEF);
        check("s_bus_sel", 32'(bus.fetch_sel), 32'd0);
        tick();
        check("sf_bus_strobes", 32'({bus.avm_read, bus.avm_write}), 32'b10);
        check("sf_bus_addr", bus.avm_address, 32'h4);
        check("sf_bus_be", 32'(bus.avm_byteenable), 32'hF);
        tick();
        check("sf_rd_stall", 32'(bus.stall), 32'd1);
        tick();
        check("sf_done_valids", 32'({bus.if_valid, bus.d_valid}), 32'b10);
        check("sf_done_rdata", bus.if_rdata, 32'h1111_2222);
        check("sf_done_sel", 32'(bus.fetch_sel), 32'd0);
        check("sf_done_stall", 32'(bus.stall), 32'd0);
        clear_req();
        tick();

        // load with three waitrequest cycles, then fetch
        bus.d_read = 1'b1;
        bus.d_addr = 32'h200;
        bus.d_byteenable = 4'hF;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h8;
        bus.avm_waitrequest = 1'b1;
        bus.avm_readdata = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("l_wait_read", 32'(bus.avm_read), 32'd1);
        end
        bus.avm_waitrequest = 1'b0;
        tick();
        check("l_rd_read", 32'(bus.avm_read), 32'd0);
        check("l_rd_err", 32'(bus.bus_err), 32'd0);
        tick();
        check("l_d_rdata", bus.d_rdata, 32'hCAFE_F00D);
        check("lf_bus_read", 32'(bus.avm_read), 32'd1);
        check("lf_bus_addr", bus.avm_address, 32'h8);
        bus.avm_readdata = 32'h1234_ABCD;
        tick();
        tick();
        check("lf_done_valids", 32'({bus.if_valid, bus.d_valid}), 32'b11);
        check("lf_done_ifrdata", bus.if_rdata, 32'h1234_ABCD);
        check("lf_done_drdata", bus.d_rdata, 32'hCAFE_F00D);
        check("lf_done_sel", 32'(bus.fetch_sel), 32'd0);
        clear_req();
        tick();

        // load timeout: waitrequest stuck high
        bus.d_read = 1'b1;
        bus.d_addr = 32'h300;
        bus.d_byteenable = 4'hF;
        bus.avm_waitrequest = 1'b1;
        bus.avm_readdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_read_held", 32'(bus.avm_read), 32'd1);
            check("to_err_low", 32'(bus.bus_err), 32'd0);
        end
        tick();
        check("to_err_set", 32'(bus.bus_err), 32'd1);
        check("to_read_drop", 32'(bus.avm_read), 32'd0);
        tick();
        check("to_done_stall", 32'(bus.stall), 32'd0);
        check("to_d_rdata", bus.d_rdata, 32'd0);
        check("to_d_valid", 32'(bus.d_valid), 32'd1);
        clear_req();
        bus.avm_waitrequest = 1'b0;
        tick();
        check("to_err_sticky", 32'(bus.bus_err), 32'd1);

        // asynchronous reset in the middle of a store
        bus.d_write = 1'b1;
        bus.d_addr = 32'h500;
        bus.d_byteenable = 4'hF;
        bus.d_writedata = 32'h5555_AAAA;
        bus.avm_waitrequest = 1'b1;
        tick();
        check("r_bus_write", 32'(bus.avm_write), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("r_async_write", 32'(bus.avm_write), 32'd0);
        check("r_async_err", 32'(bus.bus_err), 32'd0);
        clear_req();
        #1;
        check("r_async_idle", 32'(bus.stall), 32'd0);
        #2;
        reset_n = 1'b1;
        bus.avm_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("r_post_valids", 32'({bus.if_valid, bus.d_valid}), 32'd0);
            check("r_post_strobes", 32'({bus.avm_read, bus.avm_write}), 32'd0);
            check("r_post_stall", 32'(bus.stall), 32'd0);
        end
        check("r_post_drdata", bus.d_rdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
